// File: rtl/serial_adder.sv
// Bit-serial adder: operands are captured in parallel, summed LSB-first through
// a full adder built from two half adders, and the result is presented in parallel.
module half_adder (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);
    assign s = a ^ b;
    assign c = a & b;
endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             carry;
    logic [CW-1:0]    count;

    logic p;
    logic g;
    logic s_bit;
    logic t;
    logic c_bit;
    logic accept;

    half_adder u_ha0 (.a(op_a[0]), .b(op_b[0]), .s(p),     .c(g));
    half_adder u_ha1 (.a(p),       .b(carry),   .s(s_bit), .c(t));
    assign c_bit = g | t;

    assign busy   = (state == SHIFT);
    assign done   = (state == DONE);
    assign accept = start && ((state == IDLE) || (state == DONE));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            op_a  <= '0;
            op_b  <= '0;
            carry <= 1'b0;
            count <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            case (state)
                SHIFT: begin
                    carry <= c_bit;
                    op_a  <= op_a >> 1;
                    op_b  <= op_b >> 1;
                    sum   <= {s_bit, sum[WIDTH-1:1]};
                    count <= count + 1'b1;
                    if (count == CW'(WIDTH - 1)) begin
                        state <= DONE;
                        cout  <= c_bit;
                    end
                end
                default: state <= IDLE;
            endcase
            // A new request from IDLE or DONE overrides the default return to IDLE.
            if (accept) begin
                state <= SHIFT;
                op_a  <= a;
                op_b  <= b;
                carry <= 1'b0;
                count <= '0;
                sum   <= '0;
                cout  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder at WIDTH=8 and WIDTH=16 against a plain a+b model.
module tb_serial_adder;
    localparam int W8  = 8;
    localparam int W16 = 16;

    typedef struct {
        logic [32:0] val;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic start8, start16;
    logic [W8-1:0]  a8, b8, sum8;
    logic [W16-1:0] a16, b16, sum16;
    logic busy8, done8, cout8, busy16, done16, cout16;

    int tests  = 0;
    int errors = 0;
    int cyc    = 0;
    exp_t q8[$];
    exp_t q16[$];

    serial_adder #(.WIDTH(W8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );

    serial_adder #(.WIDTH(W16)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .a(a16), .b(b16),
        .busy(busy16), .done(done16), .sum(sum16), .cout(cout16)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitors: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done8 === 1'b1) begin
            if (q8.size() == 0) begin
                tests++;
                errors++;
                $display("FAIL unexpected_done8: got done=1 expected done=0 (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = q8.pop_front();
                check("result8", longint'({cout8, sum8}), longint'(e.val));
                check("latency8", cyc, e.cyc);
            end
        end
        if (done16 === 1'b1) begin
            if (q16.size() == 0) begin
                tests++;
                errors++;
                $display("FAIL unexpected_done16: got done=1 expected done=0 (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = q16.pop_front();
                check("result16", longint'({cout16, sum16}), longint'(e.val));
                check("latency16", cyc, e.cyc);
            end
        end
    end

    task automatic push8(input logic [W8-1:0] x, input logic [W8-1:0] y, input int done_cyc);
        exp_t e;
        e.val = 33'({1'b0, x} + {1'b0, y});
        e.cyc = done_cyc;
        q8.push_back(e);
    endtask

    task automatic run8(input logic [W8-1:0] x, input logic [W8-1:0] y);
        int  bcnt = 0;
        bit  seen = 0;
        @(posedge clk); #1;
        a8 = x; b8 = y; start8 = 1'b1;
        push8(x, y, cyc + 1 + W8);
        @(posedge clk); #1;
        start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
        for (int i = 0; i < W8 + 6 && !seen; i++) begin
            @(negedge clk);
            if (busy8) bcnt++;
            if (done8) seen = 1;
        end
        check("busy_len8", bcnt, W8);
        check("done_seen8", seen, 1);
    endtask

    task automatic run16(input logic [W16-1:0] x, input logic [W16-1:0] y);
        int   bcnt = 0;
        bit   seen = 0;
        exp_t e;
        @(posedge clk); #1;
        a16 = x; b16 = y; start16 = 1'b1;
        e.val = 33'({1'b0, x} + {1'b0, y});
        e.cyc = cyc + 1 + W16;
        q16.push_back(e);
        @(posedge clk); #1;
        start16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom);
        for (int i = 0; i < W16 + 6 && !seen; i++) begin
            @(negedge clk);
            if (busy16) bcnt++;
            if (done16) seen = 1;
        end
        check("busy_len16", bcnt, W16);
        check("done_seen16", seen, 1);
    endtask

    task automatic drain8();
        for (int i = 0; i < 60 && q8.size() != 0; i++) @(negedge clk);
        check("drain8", q8.size(), 0);
    endtask

    initial begin
        int hold_bad;
        rst_n = 1'b0; start8 = 1'b1; start16 = 1'b0;
        a8 = 8'hFF; b8 = 8'hFF; a16 = '0; b16 = '0;

        // Reset dominates start.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy8, 0);
        check("rst_done", done8, 0);
        check("rst_sum", sum8, 0);
        check("rst_cout", cout8, 0);
        @(posedge clk); #1;
        start8 = 1'b0; rst_n = 1'b1;
        @(negedge clk);
        check("rst_no_start", busy8, 0);

        // Basic add with hold check.
        run8(8'h0F, 8'h01);
        hold_bad = 0;
        repeat (20) begin
            @(negedge clk);
            if ({cout8, sum8} != 9'h010 || busy8 || done8) hold_bad++;
        end
        check("hold20", hold_bad, 0);

        // Carry chain and overflow.
        run8(8'hFF, 8'h01);
        run8(8'hFF, 8'hFF);
        run8(8'h00, 8'h00);

        // Start while busy is ignored and operand changes after acceptance have no effect.
        @(posedge clk); #1;
        a8 = 8'h12; b8 = 8'h34; start8 = 1'b1;
        push8(8'h12, 8'h34, cyc + 1 + W8);
        for (int i = 1; i <= 6; i++) begin
            @(posedge clk); #1;
            a8 = (i == 4) ? 8'hAA : 8'($urandom);
            b8 = (i == 4) ? 8'hAA : 8'($urandom);
            start8 = (i == 4);
        end
        start8 = 1'b0;
        drain8();
        repeat (12) @(negedge clk);

        // Reset mid-addition aborts without a done pulse.
        @(posedge clk); #1;
        a8 = 8'hF0; b8 = 8'h0F; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("abort_sum", sum8, 0);
        check("abort_busy", busy8, 0);
        repeat (12) @(negedge clk);
        run8(8'h80, 8'h80);

        // Continuous start: back-to-back operations, one done pulse each.
        @(posedge clk); #1;
        a8 = 8'h01; b8 = 8'h01; start8 = 1'b1;
        for (int j = 0; j < 4; j++) push8(8'h01, 8'h01, cyc + 1 + W8 + j * (W8 + 1));
        repeat (3 * (W8 + 1) + 1) @(posedge clk);
        #1 start8 = 1'b0;
        drain8();

        // Random runs on both widths in parallel.
        fork
            begin
                repeat (1000) begin
                    run8(8'($urandom), 8'($urandom));
                    repeat ($urandom_range(0, 2)) @(posedge clk);
                end
            end
            begin
                repeat (1000) begin
                    run16(16'($urandom), 16'($urandom));
                    repeat ($urandom_range(0, 2)) @(posedge clk);
                end
            end
        join

        repeat (4) @(negedge clk);
        check("final_q8", q8.size(), 0);
        check("final_q16", q16.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end
endmodule
